// File: rtl/rv32_bus_timer.sv
// rtl/rv32_bus_timer.sv - memory-mapped prescaled timer with compare match, auto-reload and level irq
module rv32_bus_timer #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PSC    = 3'd1;
  localparam logic [2:0] OFF_CNT    = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             ctrl_en;
  logic             ctrl_ie;
  logic             ctrl_auto;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic             match;

  logic       wr;
  logic [2:0] off;
  logic       tick;
  logic       hit;

  assign off  = busAddr[4:2];
  assign wr   = sel & busWe;
  assign tick = ctrl_en & (psc_cnt == psc);
  // Compare always sees the pre-edge CMP, so a same-edge CMP write cannot affect this tick.
  assign hit  = tick & (cnt == cmp);

  logic unused_bits;
  assign unused_bits = &{1'b0, busAddr[31:5], busAddr[1:0], busWData};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_auto <= 1'b0;
      psc       <= '0;
      psc_cnt   <= '0;
      cnt       <= '0;
      cmp       <= '1;
      match     <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL) begin
        ctrl_en   <= busWData[0];
        ctrl_ie   <= busWData[1];
        ctrl_auto <= busWData[2];
      end

      if (wr && off == OFF_PSC) begin
        psc     <= busWData[PSC_W-1:0];
        psc_cnt <= '0;
      end else if (wr && off == OFF_CNT) begin
        psc_cnt <= '0;
      end else if (ctrl_en) begin
        psc_cnt <= tick ? '0 : psc_cnt + PSC_ONE;
      end

      if (wr && off == OFF_CNT) begin
        cnt <= busWData[CNT_W-1:0];
      end else if (tick) begin
        cnt <= (hit && ctrl_auto) ? '0 : cnt + CNT_ONE;
      end

      if (wr && off == OFF_CMP) begin
        cmp <= busWData[CNT_W-1:0];
      end

      // Setting a match takes priority over a same-edge write-1-to-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr && off == OFF_STATUS && busWData[0]) begin
        match <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:   rdata = {29'b0, ctrl_auto, ctrl_ie, ctrl_en};
        OFF_PSC:    rdata = 32'(psc);
        OFF_CNT:    rdata = 32'(cnt);
        OFF_CMP:    rdata = 32'(cmp);
        OFF_STATUS: rdata = {31'b0, match};
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = match & ctrl_ie;

endmodule

// File: tb/tb_rv32_bus_timer.sv
// tb/tb_rv32_bus_timer.sv - scoreboard bench for rv32_bus_timer
module tb_rv32_bus_timer;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] rdata;
  logic        irq;

  rv32_bus_timer #(.CNT_W(32), .PSC_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .rdata    (rdata),
    .irq      (irq)
  );

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PSC    = 32'h04;
  localparam logic [31:0] A_CNT    = 32'h08;
  localparam logic [31:0] A_CMP    = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_RSVD   = 32'h18;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller sits just after a negedge; the write commits at the next posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    sel = 1'b1; busWe = 1'b1; busAddr = addr; busWData = data;
    @(negedge clk);
    sel = 1'b0; busWe = 1'b0; busWData = '0;
  endtask

  task automatic expect_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    sb_entry_t e;
    sb_q.push_back('{tag: tag, exp: exp});
    sel = 1'b1; busWe = 1'b0; busAddr = addr;
    #1;
    e = sb_q.pop_front();
    check(e.tag, rdata, e.exp);
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    sb_entry_t e;
    sb_q.push_back('{tag: tag, exp: {31'b0, exp}});
    e = sb_q.pop_front();
    check(e.tag, {31'b0, irq}, e.exp);
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    expect_read("rst_ctrl",   A_CTRL,   32'h0);
    expect_read("rst_psc",    A_PSC,    32'h0);
    expect_read("rst_cnt",    A_CNT,    32'h0);
    expect_read("rst_cmp",    A_CMP,    32'hFFFF_FFFF);
    expect_read("rst_status", A_STATUS, 32'h0);
    expect_irq ("rst_irq",    1'b0);

    bus_write(A_RSVD, 32'hDEAD_BEEF);
    expect_read("rsvd_read", A_RSVD, 32'h0);

    // Auto-reload: CNT cycles 0..3, match appears the cycle after CNT=3.
    bus_write(A_CMP, 32'd3);
    bus_write(A_PSC, 32'd0);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 9; i++) begin
      expect_read($sformatf("auto_cnt%0d", i), A_CNT, 32'(i % 4));
      expect_read($sformatf("auto_st%0d", i), A_STATUS, (i >= 4) ? 32'h1 : 32'h0);
      expect_irq ($sformatf("auto_irq%0d", i), i >= 4);
      @(negedge clk);
    end
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    expect_read("auto_clr", A_STATUS, 32'h0);

    // Prescale by 3: one count every three cycles.
    bus_write(A_CMP, 32'hFFFF_FFFF);
    bus_write(A_PSC, 32'd2);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k % 3 == 0) expect_read($sformatf("psc_k%0d", k), A_CNT, 32'(k / 3));
    end
    expect_read("psc_after30", A_CNT, 32'd10);

    // W1C on the same edge as a match set: set wins.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PSC, 32'd0);
    bus_write(A_CMP, 32'd5);
    bus_write(A_CNT, 32'd5);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_STATUS, 32'h1);
    expect_read("race_status", A_STATUS, 32'h1);
    expect_irq ("race_irq", 1'b1);
    bus_write(A_CTRL, 32'h2);
    bus_write(A_STATUS, 32'h1);
    expect_read("w1c_status", A_STATUS, 32'h0);
    expect_irq ("w1c_irq", 1'b0);
    expect_read("ctrl_readback", A_CTRL, 32'h2);

    // Wrap without AUTO: no flag on wrap, flag on 5->6 edge.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_CNT, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      expect_read($sformatf("wrap_cnt%0d", k), A_CNT, 32'hFFFF_FFFE + 32'(k));
      expect_read($sformatf("wrap_st%0d", k), A_STATUS, (k >= 8) ? 32'h1 : 32'h0);
      expect_irq ($sformatf("wrap_irq%0d", k), 1'b0);
    end

    // Async reset mid-run with CNT=7 and irq asserted.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CTRL, 32'h3);
    repeat (7) @(negedge clk);
    expect_read("pre_rst_cnt", A_CNT, 32'd7);
    expect_irq ("pre_rst_irq", 1'b1);
    reset = 1'b0;
    #1;
    expect_read("async_cnt", A_CNT, 32'd0);
    expect_irq ("async_irq", 1'b0);
    expect_read("async_cmp", A_CMP, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b0; busAddr = A_CMP;
    #1;
    check("sel0_rdata", rdata, 32'h0);
    expect_read("rsvd_0x18", A_RSVD, 32'h0);
    expect_read("post_rst_status", A_STATUS, 32'h0);

    if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
